// File: rtl/mul_share_arb.sv
// Round-robin front end that time-shares one non-pipelined multiplier among R requesters.
// One operation in flight at a time; a watchdog turns a silent multiplier into an error response.
module mul_share_arb #(
  parameter int N       = 8,
  parameter int M       = 8,
  parameter int R       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [R-1:0]     req_vld,
  input  logic [R*M-1:0]   req_a,
  input  logic [R*N-1:0]   req_b,
  output logic [R-1:0]     req_rdy,
  output logic             mul_vld,
  output logic [M-1:0]     mul_a,
  output logic [N-1:0]     mul_b,
  input  logic             mul_res_vld,
  input  logic [M+N-1:0]   mul_res,
  output logic [R-1:0]     rsp_vld,
  output logic [M+N-1:0]   rsp_res,
  output logic             rsp_err,
  input  logic [R-1:0]     rsp_rdy,
  output logic             timeout_err
);

  localparam int IW = (R > 1) ? $clog2(R) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [M-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [M+N-1:0]   res_q, res_d;
  logic             err_q, err_d;
  logic             tmo_q, tmo_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             gnt_any;
  logic [IW-1:0]    gnt_idx;
  logic [IW-1:0]    cand;

  // Rotating-priority search starting one past the last granted requester
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= R; k++) begin
      cand = IW'((int'(last_q) + k) % R);
      if (!gnt_any && req_vld[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    req_rdy = '0;
    mul_vld = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rst && gnt_any) begin
          req_rdy[gnt_idx] = 1'b1;
          a_d     = req_a[int'(gnt_idx)*M +: M];
          b_d     = req_b[int'(gnt_idx)*N +: N];
          owner_d = gnt_idx;
          last_d  = gnt_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_vld = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // cnt_q holds (WAIT cycle number - 1); a result on the last cycle still wins
        if (mul_res_vld) begin
          res_d   = mul_res;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_rdy[owner_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= IW'(R - 1);
      owner_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign rsp_vld     = (state_q == S_RESP) ? (R'(1) << owner_q) : '0;
  assign rsp_res     = res_q;
  assign rsp_err     = err_q;
  assign timeout_err = tmo_q;

endmodule

// File: doc/mul_share_arb.md
# mul_share_arb

Round-robin arbiter and sequencer sharing one non-pipelined multiplier (mul_raw style: single-cycle `vld` in, `res_vld` and `res` out after a variable latency) among R requesters.
- Accepts operand pairs over per-requester valid/ready handshakes.
- Issues exactly one multiply at a time and holds the operands stable.
- Returns the product to the owning requester.
- A watchdog converts a hung multiplier into an error response.

It sits between client blocks and the single shared multiplier instance.

## Interface
Parameters:
- N, 8, width of operand B
- M, 8, width of operand A
- R, 4, number of requesters (2..8)
- TIMEOUT, 64, maximum cycles to wait for `mul_res_vld` (≥2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_vld  in  R  request valid, one bit per requester
- req_a  in  R*M  operand A; requester i uses bits [i*M +: M]
- req_b  in  R*N  operand B; requester i uses bits [i*N +: N]
- req_rdy  out  R  one-hot accept; a request is taken when req_vld[i] and req_rdy[i] are both high
- mul_vld  out  1  single-cycle start pulse to the multiplier
- mul_a  out  M  operand A to the multiplier (registered)
- mul_b  out  N  operand B to the multiplier (registered)
- mul_res_vld  in  1  multiplier result valid
- mul_res  in  M+N  multiplier product
- rsp_vld  out  R  one-hot response valid, addressed to the owning requester
- rsp_res  out  M+N  product, held while any rsp_vld bit is high
- rsp_err  out  1  response is a timeout error (rsp_res = 0)
- rsp_rdy  in  R  response accept, one bit per requester
- timeout_err  out  1  sticky flag, set on any timeout, cleared only by rst

## Operation
The FSM has four states: IDLE, ISSUE, WAIT, RESP.

IDLE
- Arbitration is combinational: the search starts at (last+1) mod R and grants the first i with req_vld[i]=1.
- req_rdy[g] is high for exactly that one cycle.
- On the same edge: capture req_a/req_b slices into mul_a/mul_b, set owner=g, last=g, and go to ISSUE.
- If no request is valid, stay in IDLE and keep req_rdy at 0.

ISSUE
- mul_vld=1 for exactly one cycle, then go to WAIT.
- mul_res_vld is ignored in this state.

WAIT
- The watchdog counter counts cycles in WAIT.
- On mul_res_vld=1: capture mul_res, set rsp_err=0, go to RESP.
- If the count reaches TIMEOUT with no mul_res_vld: set rsp_res=0, rsp_err=1, timeout_err=1, go to RESP.

RESP
- rsp_vld[owner]=1 and rsp_res/rsp_err are held.
- On rsp_rdy[owner]=1, go to IDLE. rsp_rdy bits of other requesters are ignored.

General rules:
- mul_a/mul_b stay stable from ISSUE until the next grant.
- req_rdy is 0 in every state other than IDLE.
- mul_res_vld is sampled only in WAIT. A late or spurious pulse in any other state is dropped.
- The product is passed through unmodified: width M+N, unsigned.
- Requests not granted are not buffered. The requester keeps req_vld and its operands asserted until req_rdy.

Reset (applies at any time, including mid-operation):
- state=IDLE, last=R-1 (requester 0 has first priority).
- All outputs are 0: req_rdy, mul_vld, mul_a, mul_b, rsp_vld, rsp_res, rsp_err, timeout_err.
- Watchdog counter = 0.
- An in-flight multiply is abandoned. Its mul_res_vld, if it arrives after reset, is ignored because the FSM is in IDLE.

## Timing
- Grant to mul_vld: 1 cycle. The accept edge is t, and mul_vld is high in cycle t+1.
- Let L be the multiplier latency: mul_res_vld is first high L cycles after the mul_vld cycle. rsp_vld then rises on the edge after mul_res_vld is sampled.
- Minimum occupancy per operation is L+3 cycles (IDLE, ISSUE, WAIT×L, RESP with rsp_rdy already high).
- The next grant is evaluated in the IDLE cycle after RESP completes, so there are no back-to-back issues and at most one operation is ever outstanding.
- Timeout response: rsp_vld rises on the edge after WAIT cycle number TIMEOUT.
- Fairness: with all R requesters continuously valid, grants rotate 0,1,…,R-1,0. Worst-case wait is R-1 operations.

## Test plan
- Single requester, mul latency 2: requester 0 sends 25×5 → one mul_vld pulse with mul_a=25, mul_b=5; rsp_vld=4'b0001, rsp_res=125, rsp_err=0.
- All four requesters valid from reset with pairs (16,10), (10,4), (15,7), (215,9) → grant order 0,1,2,3; responses 160, 40, 105, 1935, each on the correct rsp_vld bit; req_rdy is never multi-hot.
- Backpressure: hold rsp_rdy[1]=0 for 10 cycles while requester 1's result for 255×255 is pending → rsp_vld[1] and rsp_res=65025 stay stable, no new req_rdy, no mul_vld; release → IDLE on the next cycle.
- Hung multiplier: mul_res_vld never asserted → after TIMEOUT=64 WAIT cycles rsp_vld[owner]=1, rsp_err=1, rsp_res=0, timeout_err=1 and stays 1. A later mul_res_vld pulse in IDLE is ignored.
- Reset mid-WAIT: assert rst for one cycle during WAIT, then deliver mul_res_vld → no response. All outputs are 0 and the next grant goes to requester 0.
- Spurious mul_res_vld in IDLE and in ISSUE → no state change, no rsp_vld; the real result that follows is returned correctly.
